systolic_sequencer: RTL
=======================

// Module: systolic_sequencer
// PURPOSE
//  Control-path sequencer for the W x W weight-stationary systolic array.
//  - Takes one matmul command and enables the requested PE columns.
//  - Loads a weight tile into the shadow buffers, then pulses switch.
//  - Streams input vectors with per-row skew.
//  - Counts results on the array outputs and signals done.
//  - Sits between the unified-buffer read ports and the array's left/top edges.
// PARAMETERS
//  SYSTOLIC_ARRAY_WIDTH  2   rows = columns of the array (W)
//  DATA_WIDTH            16  element width
//  CNT_W                 16  width of the vector and result counters
// PORTS
//  clk             in   1         clock
//  rst             in   1         asynchronous reset, active-high
//  cmd_valid       in   1         command strobe
//  cmd_ready       out  1         high only in IDLE
//  cmd_num_vec     in   CNT_W     number of input vectors to stream
//  cmd_col_size    in   16        enabled columns; values > W clamp to W
//  cmd_load_w      in   1         1 = load a new weight tile; 0 = reuse active weights
//  w_valid/w_ready in/out 1       weight-row handshake
//  w_data          in   W*DW      one weight row; column j at [j*DW +: DW]
//  d_valid/d_ready in/out 1       input-vector handshake
//  d_data          in   W*DW      one vector; row i at [i*DW +: DW]
//  sys_data_in_ix  out  DW each   skewed row data to the array
//  sys_start       out  1         valid that travels with row-1 data
//  sys_weight_in_xj out DW each   column weights
//  sys_accept_w_j  out  1 each    column weight shift enable
//  sys_switch_in   out  1         shadow-to-active pulse
//  ub_rd_col_size_in/_valid_in out 16/1  column-enable configuration
//  sys_valid_out_x1 in  1         result valid from bottom of column 1
//  busy            out  1         state != IDLE
//  done            out  1         one-cycle completion pulse
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0, except cmd_ready = 1.
//  - FSM states: IDLE, LOAD_W, SWITCH, STREAM, DRAIN, DONE.
//  - IDLE: on cmd_valid, latch the command. Next cycle, ub_rd_col_size_in = min(col_size, W)
//    with _valid_in pulsed for 1 cycle.
//    Next state: LOAD_W if cmd_load_w, otherwise STREAM.
//  - LOAD_W: w_ready = 1.
//    Each accepted beat drives sys_weight_in_xj and sets accept_w_j = 1 for enabled columns,
//    one cycle later. Cycles with no beat drive accept_w = 0 (stall, weights hold).
//    Rows are sent bottom row first. After W beats, go to SWITCH.
//  - SWITCH: sys_switch_in = 1 for exactly 1 cycle, then STREAM.
//  - STREAM: d_ready = 1.
//    An accepted beat drives row-1 data and sys_start = 1 the next cycle.
//    Row i is delayed i-1 extra cycles in the skew line.
//    Bubble cycles drive data 0 and sys_start = 0.
//    After num_vec beats, go to DRAIN. num_vec = 0 goes straight to DONE.
//  - DRAIN: sys_valid_out_x1 pulses are counted from STREAM entry, so pulses during
//    STREAM also count. When the count equals num_vec, go to DONE.
//  - DONE: done = 1 for 1 cycle, then IDLE.
//  - cmd_valid outside IDLE is ignored (cmd_ready = 0).
//  - A beat with a count that reaches its terminal value on the same cycle
//    counts normally, and the state change happens on that edge.
//  - Reset mid-operation: go to IDLE, clear all counters and the skew line.
//    Shared rst also resets the array, so any partial weight tile is discarded.
// CONFIGURATION
//  SYSTOLIC_SEQ_PERF_EN defined:
//  - Adds outputs perf_busy_cyc and perf_stall_cyc [31:0].
//  - perf_busy_cyc counts cycles with busy = 1.
//  - perf_stall_cyc counts LOAD_W/STREAM cycles with w_valid = 0 or d_valid = 0.
//  - Both counters clear on command accept and saturate at all-ones.
//  SYSTOLIC_SEQ_PERF_EN undefined: the ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - systolic_pkg holds:
//    - seq_state_e enum
//    - DATA_WIDTH default
//    - the col-size clamp function
//  - Sub-module systolic_skew: a row-indexed delay line for data, generate-based (row i depth i-1).
// TESTING
//  - W=2. Command load_w=1, col=2, num_vec=3.
//    -> col_size_valid 1 pulse with value 2.
//    -> accept_w_1 = accept_w_2 = 1 for 2 cycles, then switch for 1 cycle.
//    -> sys_start high for 3 cycles.
//    -> done after the 3rd sys_valid_out_x1 pulse.
//  - d_valid toggles 1,0,1,0,1 -> sys_start = 1,0,1,0,1.
//    -> Row-2 data lags row-1 data by exactly 1 cycle.
//  - col_size=1 -> accept_w_2 stays 0 for the whole load; col_size=9 -> ub_rd_col_size_in = 2.
//  - load_w=0, num_vec=2 -> no accept_w and no switch pulses; STREAM starts the cycle after accept.
//  - num_vec=0 -> done pulses with no sys_start. cmd_valid while busy -> ignored.
//  - rst asserted during STREAM -> all outputs 0 next edge and cmd_ready = 1.
//    -> A new command then completes normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array control path.
package systolic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StSwitch,
    StStream,
    StDrain,
    StDone
  } seq_state_e;

  localparam int unsigned DefaultDataWidth = 16;

  // Requested column count, limited to the physical array width.
  function automatic logic [15:0] clamp_col_size(input logic [15:0] col_size,
                                                 input int unsigned width);
    return (32'(col_size) > width) ? 16'(width) : col_size;
  endfunction

endpackage

// File: rtl/systolic_skew.sv
// Row-indexed delay line: row r (0-based) sees r+1 register stages, so row i (1-based)
// lags row 1 by i-1 cycles.
module systolic_skew #(
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int unsigned DATA_WIDTH           = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] in_data,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] out_data
);

  for (genvar r = 0; r < SYSTOLIC_ARRAY_WIDTH; r++) begin : g_row
    logic [DATA_WIDTH-1:0] pipe_q [0:r];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= in_data[r*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i <= r; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign out_data[r*DATA_WIDTH +: DATA_WIDTH] = pipe_q[r];
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Control-path sequencer for a W x W weight-stationary systolic array.
// Optional performance counters are built when SYSTOLIC_SEQ_PERF_EN is defined.
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int unsigned DATA_WIDTH           = DefaultDataWidth,
  parameter int unsigned CNT_W                = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       cmd_valid,
  output logic                                       cmd_ready,
  input  logic [CNT_W-1:0]                           cmd_num_vec,
  input  logic [15:0]                                cmd_col_size,
  input  logic                                       cmd_load_w,
  input  logic                                       w_valid,
  output logic                                       w_ready,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] w_data,
  input  logic                                       d_valid,
  output logic                                       d_ready,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] d_data,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] sys_data_in,
  output logic                                       sys_start,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] sys_weight_in,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]            sys_accept_w,
  output logic                                       sys_switch_in,
  output logic [15:0]                                ub_rd_col_size_in,
  output logic                                       ub_rd_col_size_valid_in,
  input  logic                                       sys_valid_out_x1,
  output logic                                       busy,
  output logic                                       done
`ifdef SYSTOLIC_SEQ_PERF_EN
  ,
  output logic [31:0]                                perf_busy_cyc,
  output logic [31:0]                                perf_stall_cyc
`endif
);

  seq_state_e                               state_q;
  logic [CNT_W-1:0]                         num_vec_q;
  logic [15:0]                              col_q;
  logic [15:0]                              w_cnt_q;
  logic [CNT_W-1:0]                         vec_cnt_q;
  logic [CNT_W-1:0]                         res_cnt_q;
  logic [CNT_W-1:0]                         res_inc;
  logic [SYSTOLIC_ARRAY_WIDTH-1:0]          col_mask;
  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] skew_in;
  logic                                     w_fire;
  logic                                     d_fire;

  // ready is registered and only ever high in its own state, so it doubles as the state qualifier
  assign w_fire  = w_valid & w_ready;
  assign d_fire  = d_valid & d_ready;
  assign skew_in = d_fire ? d_data : '0;
  assign res_inc = res_cnt_q + CNT_W'(sys_valid_out_x1);

  always_comb begin
    col_mask = '0;
    for (int j = 0; j < SYSTOLIC_ARRAY_WIDTH; j++) col_mask[j] = (16'(j) < col_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                 <= StIdle;
      num_vec_q               <= '0;
      col_q                   <= '0;
      w_cnt_q                 <= '0;
      vec_cnt_q               <= '0;
      res_cnt_q               <= '0;
      cmd_ready               <= 1'b1;
      w_ready                 <= 1'b0;
      d_ready                 <= 1'b0;
      sys_start               <= 1'b0;
      sys_weight_in           <= '0;
      sys_accept_w            <= '0;
      sys_switch_in           <= 1'b0;
      ub_rd_col_size_in       <= '0;
      ub_rd_col_size_valid_in <= 1'b0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
    end else begin
      ub_rd_col_size_valid_in <= 1'b0;
      sys_switch_in           <= 1'b0;
      sys_accept_w            <= '0;
      done                    <= 1'b0;
      sys_start               <= d_fire;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            num_vec_q               <= cmd_num_vec;
            col_q                   <= clamp_col_size(cmd_col_size, SYSTOLIC_ARRAY_WIDTH);
            ub_rd_col_size_in       <= clamp_col_size(cmd_col_size, SYSTOLIC_ARRAY_WIDTH);
            ub_rd_col_size_valid_in <= 1'b1;
            cmd_ready               <= 1'b0;
            busy                    <= 1'b1;
            w_cnt_q                 <= '0;
            vec_cnt_q               <= '0;
            res_cnt_q               <= '0;
            if (cmd_load_w) begin
              state_q <= StLoadW;
              w_ready <= 1'b1;
            end else begin
              state_q <= StStream;
              d_ready <= (cmd_num_vec != '0);
            end
          end
        end
        StLoadW: begin
          if (w_fire) begin
            sys_weight_in <= w_data;
            sys_accept_w  <= col_mask;
            w_cnt_q       <= w_cnt_q + 16'd1;
            if (w_cnt_q == 16'(SYSTOLIC_ARRAY_WIDTH - 1)) begin
              w_ready <= 1'b0;
              state_q <= StSwitch;
            end
          end
        end
        StSwitch: begin
          sys_switch_in <= 1'b1;
          state_q       <= StStream;
          d_ready       <= (num_vec_q != '0);
          res_cnt_q     <= '0;
        end
        StStream: begin
          res_cnt_q <= res_inc;
          if (num_vec_q == '0) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else if (d_fire) begin
            vec_cnt_q <= vec_cnt_q + CNT_W'(1);
            if (vec_cnt_q == num_vec_q - CNT_W'(1)) begin
              d_ready <= 1'b0;
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          res_cnt_q <= res_inc;
          if (res_inc == num_vec_q) begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  systolic_skew #(
    .SYSTOLIC_ARRAY_WIDTH(SYSTOLIC_ARRAY_WIDTH),
    .DATA_WIDTH          (DATA_WIDTH)
  ) u_skew (
    .clk     (clk),
    .rst     (rst),
    .in_data (skew_in),
    .out_data(sys_data_in)
  );

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic stall;
  assign stall = ((state_q == StLoadW) && !w_valid) || ((state_q == StStream) && !d_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if ((state_q == StIdle) && cmd_valid) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && (perf_busy_cyc != '1)) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (stall && (perf_stall_cyc != '1)) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule
